// File: rtl/param_mem_loader.sv
// Loads bus words into image banks, then byte-serialises conv and dense weights, then streams the image banks on request.
// Optional feature macro LOADER_RELOAD_IMG_EN: a write in READY reloads only the image banks.
module param_mem_loader #(
  parameter int LANES       = 4,
  parameter int ADDR_W      = 16,
  parameter int IMG_WORDS   = 196,
  parameter int CONV_WORDS  = 3484,
  parameter int DENSE_WORDS = 9395
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_chipselect,
  input  logic                 i_write,
  input  logic [8*LANES-1:0]   i_writedata,
  output logic                 o_waitrequest,
  output logic [ADDR_W-1:0]    o_img_addr,
  output logic [8*LANES-1:0]   o_img_wdata,
  output logic [LANES-1:0]     o_img_we,
  output logic [ADDR_W-1:0]    o_conv_addr,
  output logic [7:0]           o_conv_wdata,
  output logic                 o_conv_we,
  output logic [ADDR_W-1:0]    o_dense_addr,
  output logic [7:0]           o_dense_wdata,
  output logic                 o_dense_we,
  input  logic                 i_rd_start,
  output logic [ADDR_W-1:0]    o_rd_addr,
  output logic                 o_rd_en,
  output logic                 o_rd_valid,
  output logic                 o_load_done,
  output logic                 o_stream_done
);
  localparam int DW   = 8 * LANES;
  localparam int SC_W = $clog2(LANES + 1);
  localparam logic [31:0] IMG_N   = 32'(IMG_WORDS);
  localparam logic [31:0] CONV_N  = 32'(CONV_WORDS);
  localparam logic [31:0] DENSE_N = 32'(DENSE_WORDS);
  localparam logic [ADDR_W-1:0] RD_LAST = ADDR_W'(IMG_WORDS - 1);

`ifdef LOADER_RELOAD_IMG_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  typedef enum logic [2:0] {LOAD_IMG, LOAD_CONV, LOAD_DENSE, READY, STREAM} state_t;
  // Empty regions are skipped; with no dense region the conv state drains itself into READY.
  localparam state_t AFTER_IMG  = (CONV_WORDS > 0) ? LOAD_CONV : ((DENSE_WORDS > 0) ? LOAD_DENSE : READY);
  localparam state_t AFTER_CONV = (DENSE_WORDS > 0) ? LOAD_DENSE : LOAD_CONV;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_word_cnt, w_region_n;
  logic              w_wait, w_accept, w_last_word, w_words_done, w_ser_busy;
  logic              w_img_acc, w_reload_acc, w_ser_acc, w_emit, w_emit_dense;
  logic [7:0]        w_emit_byte;
  logic [DW-1:0]     r_ser_dat;
  logic [SC_W-1:0]   r_ser_cnt;
  logic              r_ser_dense, r_reload, r_load_done;
  logic [ADDR_W-1:0] r_img_ptr, r_conv_ptr, r_dense_ptr;
  logic [ADDR_W-1:0] r_img_addr, r_conv_addr, r_dense_addr, r_rd_addr;
  logic [DW-1:0]     r_img_wdata;
  logic [LANES-1:0]  r_img_we;
  logic [7:0]        r_conv_wdata, r_dense_wdata;
  logic              r_conv_we, r_dense_we, r_rd_valid, r_stream_done;

  always_comb begin
    w_region_n = IMG_N;
    case (r_state)
      LOAD_CONV:  w_region_n = CONV_N;
      LOAD_DENSE: w_region_n = DENSE_N;
      default:    w_region_n = IMG_N;
    endcase
  end

  assign w_last_word  = (w_region_n != 32'd0) && (r_word_cnt == w_region_n - 32'd1);
  assign w_words_done = (r_word_cnt == w_region_n);
  assign w_ser_busy   = (r_ser_cnt != '0);

  // Busy while bytes remain after the one on the bus, so the next word overlaps the last byte.
  always_comb begin
    w_wait = 1'b0;
    case (r_state)
      LOAD_IMG:              w_wait = (IMG_WORDS == 0);
      LOAD_CONV, LOAD_DENSE: w_wait = w_ser_busy || w_words_done;
      READY:                 w_wait = !RELOAD || (IMG_WORDS == 0);
      default:               w_wait = 1'b1;
    endcase
  end

  assign w_accept     = i_chipselect && i_write && !w_wait;
  assign w_reload_acc = w_accept && (r_state == READY);
  assign w_img_acc    = (w_accept && (r_state == LOAD_IMG)) || w_reload_acc;
  assign w_ser_acc    = w_accept && ((r_state == LOAD_CONV) || (r_state == LOAD_DENSE));
  assign w_emit       = w_ser_acc || w_ser_busy;
  assign w_emit_byte  = w_ser_acc ? i_writedata[DW-1 -: 8] : r_ser_dat[DW-1 -: 8];
  assign w_emit_dense = w_ser_acc ? (r_state == LOAD_DENSE) : r_ser_dense;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD_IMG:
        if ((IMG_WORDS == 0) || (w_accept && w_last_word))
          w_state_nxt = r_reload ? READY : AFTER_IMG;
      LOAD_CONV:
        if (w_accept && w_last_word) w_state_nxt = AFTER_CONV;
        else if (w_words_done && !w_ser_busy) w_state_nxt = READY;
      LOAD_DENSE:
        if (w_words_done && !w_ser_busy) w_state_nxt = READY;
      READY:
        if (w_reload_acc) w_state_nxt = (IMG_WORDS == 1) ? READY : LOAD_IMG;
        else if (i_rd_start && (IMG_WORDS > 0)) w_state_nxt = STREAM;
      STREAM:
        if (r_rd_addr == RD_LAST) w_state_nxt = READY;
      default: w_state_nxt = LOAD_IMG;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= LOAD_IMG;
      r_word_cnt  <= '0;
      r_reload    <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_reload_acc) r_word_cnt <= 32'd1;
      else if (w_state_nxt != r_state) r_word_cnt <= '0;
      else if (w_accept) r_word_cnt <= r_word_cnt + 32'd1;
      if (w_state_nxt == READY) r_reload <= 1'b0;
      else if (w_reload_acc) r_reload <= 1'b1;
      r_load_done <= (w_state_nxt == READY) || (w_state_nxt == STREAM);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_img_ptr   <= '0;
      r_img_addr  <= '0;
      r_img_wdata <= '0;
      r_img_we    <= '0;
    end else begin
      r_img_we <= w_img_acc ? '1 : '0;
      if (w_img_acc) begin
        r_img_wdata <= i_writedata;
        r_img_addr  <= w_reload_acc ? '0 : r_img_ptr;
        r_img_ptr   <= w_reload_acc ? ADDR_W'(1) : r_img_ptr + ADDR_W'(1);
      end
    end
  end

  // The MSB byte goes out straight from the bus word; the remainder is shifted out of r_ser_dat.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ser_dat   <= '0;
      r_ser_cnt   <= '0;
      r_ser_dense <= 1'b0;
    end else if (w_ser_acc) begin
      r_ser_dat   <= i_writedata << 8;
      r_ser_cnt   <= SC_W'(LANES - 1);
      r_ser_dense <= (r_state == LOAD_DENSE);
    end else if (w_ser_busy) begin
      r_ser_dat <= r_ser_dat << 8;
      r_ser_cnt <= r_ser_cnt - SC_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_conv_ptr    <= '0;
      r_conv_addr   <= '0;
      r_conv_wdata  <= '0;
      r_conv_we     <= 1'b0;
      r_dense_ptr   <= '0;
      r_dense_addr  <= '0;
      r_dense_wdata <= '0;
      r_dense_we    <= 1'b0;
    end else begin
      r_conv_we  <= w_emit && !w_emit_dense;
      r_dense_we <= w_emit && w_emit_dense;
      if (w_emit && !w_emit_dense) begin
        r_conv_wdata <= w_emit_byte;
        r_conv_addr  <= r_conv_ptr;
        r_conv_ptr   <= r_conv_ptr + ADDR_W'(1);
      end
      if (w_emit && w_emit_dense) begin
        r_dense_wdata <= w_emit_byte;
        r_dense_addr  <= r_dense_ptr;
        r_dense_ptr   <= r_dense_ptr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_addr     <= '0;
      r_rd_valid    <= 1'b0;
      r_stream_done <= 1'b0;
    end else begin
      r_rd_addr     <= ((r_state == STREAM) && (w_state_nxt == STREAM)) ? r_rd_addr + ADDR_W'(1) : '0;
      r_rd_valid    <= (r_state == STREAM);
      r_stream_done <= (r_state == STREAM) && (r_rd_addr == RD_LAST);
    end
  end

  assign o_waitrequest = w_wait;
  assign o_img_addr    = r_img_addr;
  assign o_img_wdata   = r_img_wdata;
  assign o_img_we      = r_img_we;
  assign o_conv_addr   = r_conv_addr;
  assign o_conv_wdata  = r_conv_wdata;
  assign o_conv_we     = r_conv_we;
  assign o_dense_addr  = r_dense_addr;
  assign o_dense_wdata = r_dense_wdata;
  assign o_dense_we    = r_dense_we;
  assign o_rd_addr     = r_rd_addr;
  assign o_rd_en       = (r_state == STREAM);
  assign o_rd_valid    = r_rd_valid;
  assign o_load_done   = r_load_done;
  assign o_stream_done = r_stream_done;
endmodule

// File: tb/tb_param_mem_loader.sv
// Directed bench for param_mem_loader with LANES=4, IMG_WORDS=2, CONV_WORDS=2, DENSE_WORDS=1.
module tb_param_mem_loader;
`ifdef LOADER_RELOAD_IMG_EN
  localparam bit RLD = 1'b1;
`else
  localparam bit RLD = 1'b0;
`endif

  typedef struct packed {
    logic        wr_wait;
    logic [3:0]  img_we;
    logic [15:0] img_addr;
    logic [31:0] img_wdata;
    logic        conv_we;
    logic [15:0] conv_addr;
    logic [7:0]  conv_wdata;
    logic        dense_we;
    logic [15:0] dense_addr;
    logic [7:0]  dense_wdata;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic        rd_valid;
    logic        load_done;
    logic        stream_done;
  } out_t;

  typedef struct {
    logic        cs;
    logic        wr;
    logic [31:0] wdata;
    logic        rs;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, cs, wr, rs;
  logic [31:0] wd;
  logic        o_waitrequest, o_conv_we, o_dense_we, o_rd_en, o_rd_valid, o_load_done, o_stream_done;
  logic [15:0] o_img_addr, o_conv_addr, o_dense_addr, o_rd_addr;
  logic [31:0] o_img_wdata;
  logic [3:0]  o_img_we;
  logic [7:0]  o_conv_wdata, o_dense_wdata;
  int          total = 0;
  int          bad = 0;
  vec_t        tbl[$];

  always #5 clk = ~clk;

  param_mem_loader #(.LANES(4), .ADDR_W(16), .IMG_WORDS(2), .CONV_WORDS(2), .DENSE_WORDS(1)) dut (
    .i_clk(clk), .i_reset(rst), .i_chipselect(cs), .i_write(wr), .i_writedata(wd),
    .o_waitrequest(o_waitrequest),
    .o_img_addr(o_img_addr), .o_img_wdata(o_img_wdata), .o_img_we(o_img_we),
    .o_conv_addr(o_conv_addr), .o_conv_wdata(o_conv_wdata), .o_conv_we(o_conv_we),
    .o_dense_addr(o_dense_addr), .o_dense_wdata(o_dense_wdata), .o_dense_we(o_dense_we),
    .i_rd_start(rs), .o_rd_addr(o_rd_addr), .o_rd_en(o_rd_en), .o_rd_valid(o_rd_valid),
    .o_load_done(o_load_done), .o_stream_done(o_stream_done)
  );

  function automatic out_t sample();
    out_t o;
    o.wr_wait = o_waitrequest;  o.img_we = o_img_we;   o.img_addr = o_img_addr;
    o.img_wdata = o_img_wdata;  o.conv_we = o_conv_we; o.conv_addr = o_conv_addr;
    o.conv_wdata = o_conv_wdata; o.dense_we = o_dense_we; o.dense_addr = o_dense_addr;
    o.dense_wdata = o_dense_wdata; o.rd_en = o_rd_en; o.rd_addr = o_rd_addr;
    o.rd_valid = o_rd_valid; o.load_done = o_load_done; o.stream_done = o_stream_done;
    return o;
  endfunction

  function automatic out_t mk(input int w, iwe, ia, input logic [31:0] id, input int cwe, ca, cd,
                              input int dwe, da, dd, re, ra, rv, ld, sd);
    out_t o;
    o.wr_wait = 1'(w);   o.img_we = 4'(iwe);     o.img_addr = 16'(ia);  o.img_wdata = id;
    o.conv_we = 1'(cwe); o.conv_addr = 16'(ca);  o.conv_wdata = 8'(cd);
    o.dense_we = 1'(dwe); o.dense_addr = 16'(da); o.dense_wdata = 8'(dd);
    o.rd_en = 1'(re);    o.rd_addr = 16'(ra);    o.rd_valid = 1'(rv);
    o.load_done = 1'(ld); o.stream_done = 1'(sd);
    return o;
  endfunction

  task automatic add(input logic c, w, input logic [31:0] d, input logic r, input out_t e);
    vec_t v;
    v.cs = c; v.wr = w; v.wdata = d; v.rs = r; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input out_t act, input out_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    cs = 1'b0; wr = 1'b0; wd = '0; rs = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_state", sample(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Columns of mk: wait, img_we, img_addr, img_wdata, conv we/addr/data, dense we/addr/data,
    // rd_en, rd_addr, rd_valid, load_done, stream_done -- all as seen during that cycle.
    add(1, 0, 32'hFFFFFFFF, 0, mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 32'hFFFFFFFF, 1, mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 32'hAABBCCDD, 0, mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 32'h11223344, 0, mk(0, 15, 0, 32'hAABBCCDD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 32'h01020304, 0, mk(0, 15, 1, 32'h11223344, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 32'h05060708, 0, mk(1, 0, 1, 32'h11223344, 1, 0, 8'h01, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 32'h05060708, 0, mk(1, 0, 1, 32'h11223344, 1, 1, 8'h02, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 32'h05060708, 0, mk(1, 0, 1, 32'h11223344, 1, 2, 8'h03, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 32'h05060708, 0, mk(0, 0, 1, 32'h11223344, 1, 3, 8'h04, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 32'h0A0B0C0D, 0, mk(1, 0, 1, 32'h11223344, 1, 4, 8'h05, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 32'h0A0B0C0D, 0, mk(1, 0, 1, 32'h11223344, 1, 5, 8'h06, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 32'h0A0B0C0D, 0, mk(1, 0, 1, 32'h11223344, 1, 6, 8'h07, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 32'h0A0B0C0D, 0, mk(0, 0, 1, 32'h11223344, 1, 7, 8'h08, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 32'h0, 1, mk(1, 0, 1, 32'h11223344, 0, 7, 8'h08, 1, 0, 8'h0A, 0, 0, 0, 0, 0));
    add(0, 0, 32'h0, 0, mk(1, 0, 1, 32'h11223344, 0, 7, 8'h08, 1, 1, 8'h0B, 0, 0, 0, 0, 0));
    add(0, 0, 32'h0, 0, mk(1, 0, 1, 32'h11223344, 0, 7, 8'h08, 1, 2, 8'h0C, 0, 0, 0, 0, 0));
    add(0, 0, 32'h0, 0, mk(1, 0, 1, 32'h11223344, 0, 7, 8'h08, 1, 3, 8'h0D, 0, 0, 0, 0, 0));
    add(0, 0, 32'h0, 1, mk(RLD ? 0 : 1, 0, 1, 32'h11223344, 0, 7, 8'h08, 0, 3, 8'h0D, 0, 0, 0, 1, 0));
    add(0, 0, 32'h0, 0, mk(1, 0, 1, 32'h11223344, 0, 7, 8'h08, 0, 3, 8'h0D, 1, 0, 0, 1, 0));
    add(0, 0, 32'h0, 0, mk(1, 0, 1, 32'h11223344, 0, 7, 8'h08, 0, 3, 8'h0D, 1, 1, 1, 1, 0));
    add(0, 0, 32'h0, 0, mk(RLD ? 0 : 1, 0, 1, 32'h11223344, 0, 7, 8'h08, 0, 3, 8'h0D, 0, 0, 1, 1, 1));
    add(0, 0, 32'h0, 0, mk(RLD ? 0 : 1, 0, 1, 32'h11223344, 0, 7, 8'h08, 0, 3, 8'h0D, 0, 0, 0, 1, 0));

    do_reset();
    foreach (tbl[i]) begin
      @(negedge clk);
      cs = tbl[i].cs; wr = tbl[i].wr; wd = tbl[i].wdata; rs = tbl[i].rs;
      #1;
      check($sformatf("vec%0d", i), sample(), tbl[i].exp);
    end

    // Write while READY: reloads the image banks only when the reload feature is built in.
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; wd = 32'hDEADBEEF; rs = 1'b0;
    #1;
    chk("ready_wait", 32'(o_waitrequest), RLD ? 32'h0 : 32'h1);
    @(negedge clk);
    wd = 32'h55667788;
    #1;
    chk("ready_img_we", 32'(o_img_we), RLD ? 32'hF : 32'h0);
    chk("ready_img_addr", 32'(o_img_addr), RLD ? 32'h0 : 32'h1);
    chk("ready_img_wdata", o_img_wdata, RLD ? 32'hDEADBEEF : 32'h11223344);
    chk("ready_load_done", 32'(o_load_done), RLD ? 32'h0 : 32'h1);
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    #1;
    chk("reload_img_we2", 32'(o_img_we), RLD ? 32'hF : 32'h0);
    chk("reload_img_wdata2", o_img_wdata, RLD ? 32'h55667788 : 32'h11223344);
    chk("reload_load_done2", 32'(o_load_done), 32'h1);

    // Reset in the middle of serialising a conv word.
    @(negedge clk);
    do_reset();
    @(negedge clk); cs = 1'b1; wr = 1'b1; wd = 32'h01010101;
    @(negedge clk); wd = 32'h02020202;
    @(negedge clk); wd = 32'h01020304;
    @(negedge clk); cs = 1'b0; wr = 1'b0; wd = '0;
    #1;
    chk("mid_conv_addr0", 32'(o_conv_addr), 32'h0);
    @(negedge clk);
    #1;
    chk("mid_conv_we", 32'(o_conv_we), 32'h1);
    chk("mid_conv_byte2", 32'(o_conv_wdata), 32'h02);
    chk("mid_conv_wait", 32'(o_waitrequest), 32'h1);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", sample(), '0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_reset_no_conv%0d", k), 32'(o_conv_we), 32'h0);
    end
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; wd = 32'hCAFEF00D;
    #1;
    chk("post_reset_wait", 32'(o_waitrequest), 32'h0);
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    #1;
    chk("post_reset_img_we", 32'(o_img_we), 32'hF);
    chk("post_reset_img_addr", 32'(o_img_addr), 32'h0);
    chk("post_reset_img_wdata", o_img_wdata, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_mem_loader.md
PARAM_MEM_LOADER -- requirements
Module: param_mem_loader

Interface
REQ-001 Parameter LANES, default 4: image banks and bytes per bus word; legal range 1..8.
REQ-002 Parameter ADDR_W, default 16: width of every RAM address output.
REQ-003 Parameter IMG_WORDS, default 196: bus words per image, one bank address per word.
REQ-004 Parameter CONV_WORDS, default 3484: bus words of conv weights, each serialised to LANES bytes.
REQ-005 Parameter DENSE_WORDS, default 9395: bus words of dense weights, each serialised to LANES bytes.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 chipselect, write  in  1 each  bus write qualifiers; a write is accepted when both are high and waitrequest is low.
REQ-009 writedata  in  8*LANES  bus word; byte LANES-1 is the MSB.
REQ-010 waitrequest  out  1  loader cannot accept a write this cycle.
REQ-011 img_addr, img_wdata, img_we  out  ADDR_W, 8*LANES, LANES  image-bank write port; bank k takes byte k.
REQ-012 conv_addr, conv_wdata, conv_we  out  ADDR_W, 8, 1  conv weight RAM write port.
REQ-013 dense_addr, dense_wdata, dense_we  out  ADDR_W, 8, 1  dense weight RAM write port.
REQ-014 rd_start  in  1  request to stream the image banks.
REQ-015 rd_addr, rd_en, rd_valid  out  ADDR_W, 1, 1  image read address, read strobe, and bank-data-valid flag.
REQ-016 load_done, stream_done  out  1 each  level flag for all regions loaded; one-cycle pulse at end of stream.

Function
REQ-017 States: LOAD_IMG, LOAD_CONV, LOAD_DENSE, READY, STREAM; reset enters LOAD_IMG.
REQ-018 Write ports are registered: a word accepted in cycle t produces its first RAM write strobe in cycle t+1.
REQ-019 In LOAD_IMG, each accepted word drives all LANES img_we bits high for one cycle at img_addr, which starts at 0 and increments by 1 per word.
REQ-020 After IMG_WORDS words, the state moves to LOAD_CONV, or to the next non-empty region when a region's word count is 0.
REQ-021 In LOAD_CONV and LOAD_DENSE, each accepted word is serialised MSB byte first over cycles t+1..t+LANES, one write strobe per cycle, with the address incrementing per byte from 0.
REQ-022 waitrequest is high while the serialiser holds more than one pending byte, so a new word can be accepted in the cycle the last byte is driven; sustained throughput is 1 word per LANES cycles.
REQ-023 After the last dense byte is written, the state moves to READY and load_done goes high and stays high until reset.
REQ-024 waitrequest is high in STREAM; writes in READY follow REQ-031.
REQ-025 rd_start high in READY enters STREAM.
REQ-026 In STREAM, rd_en is high for IMG_WORDS consecutive cycles with rd_addr = 0..IMG_WORDS-1.
REQ-027 rd_valid equals rd_en delayed by 1 cycle, matching the bank read latency.
REQ-028 stream_done pulses together with the last rd_valid, and the state then returns to READY.
REQ-029 rd_start outside READY is ignored.
REQ-030 chipselect low or write low leaves all counters unchanged.

Configuration
REQ-031 With LOADER_RELOAD_IMG_EN defined, an accepted write in READY restarts LOAD_IMG at img_addr 0 with that word, keeps the weight RAM contents, and clears load_done until IMG_WORDS words are reloaded, then returns to READY.
REQ-032 Without LOADER_RELOAD_IMG_EN defined, waitrequest is high in READY, writes are ignored, and only reset restarts loading.

Reset
REQ-033 Asserting reset immediately clears all addresses, counters, the serialiser, every *_we, rd_en, rd_valid, load_done and stream_done to 0, sets waitrequest to 0, and selects LOAD_IMG.
REQ-034 Reset asserted mid-serialisation discards the pending bytes, with no partial write after release.

Verification (LANES=4, IMG_WORDS=2, CONV_WORDS=2, DENSE_WORDS=1)
REQ-035 Writes 0xAABBCCDD, 0x11223344 -> img_we=4'hF at img_addr 0 then 1; bank3 receives 0xAA then 0x11.
REQ-036 Write 0x01020304 in LOAD_CONV -> conv_wdata 01,02,03,04 at conv_addr 0..3 on consecutive cycles; waitrequest high for 3 cycles.
REQ-037 Back-to-back master writes through the dense region -> dense bytes at addr 0..3, then load_done=1 and the state is READY.
REQ-038 rd_start in READY -> rd_addr 0,1 with rd_en high; rd_valid high 1 cycle later; stream_done coincides with the second rd_valid.
REQ-039 reset pulsed during the second conv byte -> all outputs 0 within the same cycle; the next write lands at img_addr 0.
REQ-040 Write in READY -> with LOADER_RELOAD_IMG_EN: img_we at addr 0 and load_done=0; without it: waitrequest=1 and no strobe.
